process_images_udiv_60ns_30ns_30_seq: RTL
=========================================

PROCESS_IMAGES_UDIV_60NS_30NS_30_SEQ -- requirements
Module: process_images_udiv_60ns_30ns_30_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier, no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 0, informational only, no functional effect.
REQ-003 SHALL have parameter din0_WIDTH, default 60, dividend width; must be exactly 2*dout_WIDTH.
REQ-004 SHALL have parameter din1_WIDTH, default 30, divisor width; must equal dout_WIDTH.
REQ-005 SHALL have parameter dout_WIDTH, default 30, quotient and remainder width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port ce, input, 1 bit: clock enable; when low, all state holds.
REQ-009 SHALL have port start, input, 1 bit: request to begin a division.
REQ-010 SHALL have port ready, output, 1 bit: high in IDLE, when start is accepted.
REQ-011 SHALL have port din0, input, din0_WIDTH: unsigned dividend, sampled on accept.
REQ-012 SHALL have port din1, input, din1_WIDTH: unsigned divisor, sampled on accept.
REQ-013 SHALL have port dout, output, dout_WIDTH: quotient.
REQ-014 SHALL have port rem, output, dout_WIDTH: remainder.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when dout and rem become valid.
REQ-016 SHALL have port dbz, output, 1 bit: the result is a divide-by-zero result.
REQ-017 SHALL have port ovf, output, 1 bit: the quotient does not fit in dout_WIDTH bits.

Function
REQ-018 SHALL implement the FSM states IDLE, CALC and FINISH.
REQ-019 SHALL, in IDLE with start=1 and ce=1, accept the operands, register din0 and din1, and go to CALC (or to FINISH when din1==0).
REQ-020 SHALL execute restoring division in CALC, one quotient bit per ce-qualified cycle, MSB first, for exactly dout_WIDTH cycles.
REQ-021 SHALL use a dout_WIDTH+1-bit partial remainder initialised to din0[din0_WIDTH-1:dout_WIDTH].
REQ-022 SHALL perform each step as follows: shift the next dividend bit in; if partial >= divisor, subtract the divisor and set the quotient bit to 1, else set it to 0.
REQ-023 SHALL enter FINISH after the last iteration, assert done for one ce-cycle, and return to IDLE.
REQ-024 SHALL give a latency from the accepting edge to done high of dout_WIDTH+1 ce-cycles (31 at the defaults); the dbz path SHALL give 1 ce-cycle.
REQ-025 SHALL hold dout, rem, dbz and ovf stable from done until the next done; they SHALL change only in FINISH.
REQ-026 SHALL ignore start outside IDLE; ready SHALL be low in CALC and FINISH.
REQ-027 SHALL freeze the FSM, counter, datapath and done while ce=0; a pending done pulse SHALL be extended until the next ce-cycle.
REQ-028 SHALL, on divide by zero (din1==0), set dout to all ones, rem to din0[dout_WIDTH-1:0], dbz=1 and ovf=0.
REQ-029 SHALL clear dbz on any non-zero-divisor result.
REQ-030 SHALL treat all arithmetic as unsigned, with no X propagation from unused operand bits.

Reset
REQ-031 SHALL, with reset=1 on a clock edge, force IDLE, ready=1, done=0, dout=0, rem=0, dbz=0, ovf=0 and iteration counter=0, regardless of ce.
REQ-032 SHALL abandon an operation when reset arrives mid-operation; no done is produced for it.
REQ-033 SHALL accept start on the first edge after reset deasserts.

Configuration
REQ-034 SHALL, with PROCESS_IMAGES_UDIV_OVF_CHECK_EN defined, compare din0[din0_WIDTH-1:dout_WIDTH] >= din1 at accept (din1 != 0); on overflow it SHALL skip CALC, go to FINISH, set dout to all ones, rem to 0 and ovf=1.
REQ-035 SHALL, without the macro, tie ovf to 0 and run overflowing operands through CALC; dout and rem are then unspecified, but done timing is still REQ-024.

Structure
REQ-036 SHALL place the FSM state enum (IDLE/CALC/FINISH), the default widths and the counter width ($clog2(dout_WIDTH+1)) in package process_images_div_pkg.
REQ-037 SHALL implement the combinational compare/subtract step in one sub-module, process_images_udiv_step, instantiated once; the top holds the FSM and registers.

Verification
REQ-038 SHALL cover: din0=100, din1=7, start for 1 cycle, ce=1 -> done exactly 31 cycles later, dout=14, rem=2, dbz=0, ovf=0.
REQ-039 SHALL cover: din0=(2^30-1)^2, din1=2^30-1 -> dout=2^30-1, rem=0.
REQ-040 SHALL cover: din0=5, din1=0 -> done 1 cycle later, dout=0x3FFFFFFF, rem=5, dbz=1.
REQ-041 SHALL cover, with the macro: din0=2^30, din1=1 -> done 1 cycle later, ovf=1, dout=0x3FFFFFFF, rem=0; without the macro: ovf stays 0.
REQ-042 SHALL cover: 100/7 with ce low for 5 cycles mid-CALC -> done at 36 cycles and the same result; a start issued during CALC is ignored.
REQ-043 SHALL cover: reset pulsed 10 cycles into CALC -> no done, all outputs 0 and ready=1; the next 9/3 gives dout=3, rem=0.

Source files
------------

// File: rtl/process_images_div_pkg.sv
// Shared types and defaults for the sequential 60/30 unsigned divider.
// Optional feature macro: PROCESS_IMAGES_UDIV_OVF_CHECK_EN (early quotient-overflow exit).
package process_images_div_pkg;

  localparam int DIN0_W_DEF = 60;
  localparam int DIN1_W_DEF = 30;
  localparam int DOUT_W_DEF = 30;

  // Iteration counter must hold 0..dout_WIDTH.
  localparam int CNT_W = $clog2(DOUT_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/process_images_udiv_60ns_30ns_30_seq_if.sv
// Operand/result bundle for the sequential divider.
// Handshake: the master holds start with din0/din1 stable; the divider accepts on a rising
// clk edge where start, ready and ce are all high. done is high for exactly one ce-qualified
// cycle (longer if ce is low) and dout/rem/dbz/ovf are valid from done until the next done.
interface process_images_udiv_60ns_30ns_30_seq_if #(
  parameter int DIN0_W = 60,
  parameter int DIN1_W = 30,
  parameter int DOUT_W = 30
);
  logic              ce;
  logic              start;
  logic              ready;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic [DOUT_W-1:0] dout;
  logic [DOUT_W-1:0] rem;
  logic              done;
  logic              dbz;
  logic              ovf;

  modport master (
    output ce, start, din0, din1,
    input  ready, dout, rem, done, dbz, ovf
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, dout, rem, done, dbz, ovf
  );
endinterface

// File: rtl/process_images_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and report the resulting quotient bit.
module process_images_udiv_step #(
  parameter int W = 30
) (
  input  logic [W:0]   part_i,
  input  logic         din_bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   part_o,
  output logic         q_bit_o
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  // Compare/subtract; the subtraction is only used when the shifted value is >= divisor,
  // so the truncated difference is exact.
  always_comb begin
    shifted = {part_i, din_bit_i};
    diff    = shifted[W:0] - {1'b0, divisor_i};
    q_bit_o = (shifted >= {2'b00, divisor_i});
    part_o  = q_bit_o ? diff : shifted[W:0];
  end

endmodule

// File: rtl/process_images_udiv_60ns_30ns_30_seq.sv
// Sequential unsigned divider: 2W-bit dividend / W-bit divisor, one quotient bit per
// ce-qualified cycle. Divide-by-zero finishes in one cycle with dbz set.
// Optional feature macro: PROCESS_IMAGES_UDIV_OVF_CHECK_EN -- when defined, operands whose
// quotient cannot fit in W bits skip the iteration and finish at once with ovf set.
module process_images_udiv_60ns_30ns_30_seq
  import process_images_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 0,
  parameter int din0_WIDTH = DIN0_W_DEF,
  parameter int din1_WIDTH = DIN1_W_DEF,
  parameter int dout_WIDTH = DOUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  output logic                  ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  done,
  output logic                  dbz,
  output logic                  ovf,
  output div_state_e            dbg_state
);

  localparam int W  = dout_WIDTH;
  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  // The datapath assumes the classic 2W/W shape; reject anything else at elaboration.
  if (din0_WIDTH != 2 * dout_WIDTH || din1_WIDTH != dout_WIDTH || ID < 0 || NUM_STAGE < 0)
  begin : g_bad_params
    $error("process_images_udiv: unsupported parameter combination");
  end

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    part_q, part_d;
  // Low dividend bits shift out MSB-first while quotient bits shift in at the bottom.
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [W:0]    step_part;
  logic          step_q;
  logic          ovf_hit;

`ifdef PROCESS_IMAGES_UDIV_OVF_CHECK_EN
  assign ovf_hit = (din1 != '0) && (din0[din0_WIDTH-1:W] >= din1);
`else
  assign ovf_hit = 1'b0;
`endif

  process_images_udiv_step #(.W(W)) u_step (
    .part_i    (part_q),
    .din_bit_i (lo_q[W-1]),
    .divisor_i (dvs_q),
    .part_o    (step_part),
    .q_bit_o   (step_q)
  );

  // State and datapath registers; reset wins over ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; everything holds while ce is low.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      unique case (state_q)
        IDLE:    if (start) state_d = ((din1 == '0) || ovf_hit) ? FINISH : CALC;
        CALC:    if (cnt_q == LAST_CNT) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: ready in IDLE, done for the whole FINISH state (stretched by ce=0).
  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == FINISH);
    dbg_state = state_q;
  end

  // Datapath: load on accept, one restoring step per CALC cycle, results land on FINISH entry.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    lo_d   = lo_q;
    dvs_d  = dvs_q;
    dout_d = dout_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            part_d = {1'b0, din0[din0_WIDTH-1:W]};
            lo_d   = din0[W-1:0];
            dvs_d  = din1;
            cnt_d  = '0;
            if (din1 == '0) begin
              dout_d = '1;
              rem_d  = din0[W-1:0];
              dbz_d  = 1'b1;
              ovf_d  = 1'b0;
            end else if (ovf_hit) begin
              dout_d = '1;
              rem_d  = '0;
              dbz_d  = 1'b0;
              ovf_d  = 1'b1;
            end
          end
        end
        CALC: begin
          part_d = step_part;
          lo_d   = {lo_q[W-2:0], step_q};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            dout_d = {lo_q[W-2:0], step_q};
            rem_d  = step_part[W-1:0];
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = dout_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule
